uart_rx: RTL and testbench

//   UART receiver, 8N1, LSB first; receive-side counterpart of uart_tx on the same serial line.

---
 rtl/uart_rx.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined), LSB first.
// The rx line passes through a synchroniser. A start bit is qualified at mid-bit.
// Each later bit is sampled one bit period after the previous sample, which is mid-bit.
//
// Optional feature macro: UART_RX_PARITY_EN (even parity bit between data and stop).
//
// Ports:
//   clk        in   system clock
//   reset_n    in   synchronous reset, active low
//   rx         in   serial input, idle high, asynchronous to clk
//   rx_data    out  last good received byte, held until the next good frame
//   rx_valid   out  one-cycle strobe, rx_data updated
//   rx_busy    out  high from detected start edge until the frame ends
//   frame_err  out  one-cycle strobe, stop bit sampled low
//   parity_err out  one-cycle strobe, parity mismatch (constant 0 without the macro)
//
// CLKS_PER_BIT must be >= 4 and SYNC_STAGES must be >= 2.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      PARITY  = 3'd3,
      STOP    = 3'd4,
      CLEANUP = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd4,
      CLEANUP = 3'd5
   } state_t;
`endif

   logic [SYNC_STAGES-1:0] sync;
   logic                   rx_s;
   logic                   rx_prev;

   state_t           state,     state_nxt;
   logic [CNT_W-1:0] cnt,       cnt_nxt;
   logic [2:0]       idx,       idx_nxt;
   logic [7:0]       shift,     shift_nxt;
   logic [7:0]       data_nxt;
   logic             valid_nxt;
   logic             busy_nxt;
   logic             ferr_nxt;
   logic             wrap;

`ifdef UART_RX_PARITY_EN
   logic             par_bad,   par_bad_nxt;
   logic             perr_nxt;
   logic             perr_q;
`endif

   assign rx_s = sync[SYNC_STAGES-1];
   assign wrap = (cnt == CNT_LAST);

   // Input synchroniser and previous-sample register for edge detection
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync    <= {SYNC_STAGES{1'b1}};
         rx_prev <= 1'b1;
      end else begin
         sync    <= {sync[SYNC_STAGES-2:0], rx};
         rx_prev <= rx_s;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shift     <= '0;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         rx_busy   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         idx       <= idx_nxt;
         shift     <= shift_nxt;
         rx_data   <= data_nxt;
         rx_valid  <= valid_nxt;
         rx_busy   <= busy_nxt;
         frame_err <= ferr_nxt;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity status and strobe registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         par_bad <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         par_bad <= par_bad_nxt;
         perr_q  <= perr_nxt;
      end
   end
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

   // Next-state, datapath and strobe logic
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      shift_nxt = shift;
      data_nxt  = rx_data;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_nxt = par_bad;
      perr_nxt    = 1'b0;
`endif

      case (state)
         IDLE: begin
            idx_nxt = '0;
            if (!rx_s && rx_prev) state_nxt = START;
         end
         START: begin
`ifdef UART_RX_PARITY_EN
            par_bad_nxt = 1'b0;
`endif
            // Line back high at mid start bit is a glitch, not a frame
            if (cnt == CNT_HALF) state_nxt = rx_s ? IDLE : DATA;
         end
         DATA: begin
            if (wrap) begin
               shift_nxt = {rx_s, shift[7:1]};
               if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end else begin
                  idx_nxt = idx + 3'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (wrap) begin
               par_bad_nxt = rx_s ^ (^shift);
               state_nxt   = STOP;
            end
         end
`endif
         STOP: begin
            if (wrap) begin
               state_nxt = CLEANUP;
               if (!rx_s) begin
                  ferr_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (par_bad) begin
                  perr_nxt = 1'b1;
`endif
               end else begin
                  data_nxt  = shift;
                  valid_nxt = 1'b1;
               end
            end
         end
         CLEANUP: begin
            // Holds while the line is low (break or stuck-low line)
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      if ((state_nxt != state) || wrap) cnt_nxt = '0;
      else                              cnt_nxt = cnt + CNT_W'(1);

      busy_nxt = (state_nxt == START) || (state_nxt == DATA) || (state_nxt == STOP);
`ifdef UART_RX_PARITY_EN
      if (state_nxt == PARITY) busy_nxt = 1'b1;
`endif
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at CLKS_PER_BIT=434.
module tb_uart_rx;

   localparam int unsigned CPB  = 434;
   localparam int unsigned SYNC = 2;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;
   logic       parity_err;

   int vectors     = 0;
   int miscompares = 0;
   int valid_cnt   = 0;
   int ferr_cnt    = 0;
   int perr_cnt    = 0;
   int adj_err     = 0;
   int v0, f0, p0;
   logic [7:0] log_q[$];
   logic       busy_mid;
   logic       prev_strobe = 1'b0;

   uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_busy    (rx_busy),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   always #10 clk = ~clk;

   // Strobe monitor: counts pulses, logs data, flags overlap or back-to-back strobes
   always @(negedge clk) begin
      if (rx_valid) begin
         valid_cnt++;
         log_q.push_back(rx_data);
      end
      if (frame_err)  ferr_cnt++;
      if (parity_err) perr_cnt++;
      if ((int'(rx_valid) + int'(frame_err) + int'(parity_err)) > 1) adj_err++;
      if (prev_strobe && (rx_valid || frame_err || parity_err)) adj_err++;
      prev_strobe = rx_valid || frame_err || parity_err;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bit_time(input logic v);
      @(negedge clk) rx = v;
      repeat (CPB - 1) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      @(negedge clk) rx = 1'b0;
      repeat (CPB / 2) @(negedge clk);
      busy_mid = rx_busy;
      repeat (CPB - 1 - CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
      bit_time(par);
`endif
      bit_time(stop);
   endtask

   initial begin
      rx      = 1'b1;
      reset_n = 1'b0;
      repeat (5) @(negedge clk);
      chk("reset_rx_data",    32'(rx_data),    32'h00);
      chk("reset_rx_valid",   32'(rx_valid),   32'h0);
      chk("reset_rx_busy",    32'(rx_busy),    32'h0);
      chk("reset_frame_err",  32'(frame_err),  32'h0);
      chk("reset_parity_err", 32'(parity_err), 32'h0);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);

      // Single good byte A5
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(8'hA5, ^8'hA5, 1'b1);
      repeat (10) @(negedge clk);
      chk("a5_busy_mid",  32'(busy_mid),      32'h1);
      chk("a5_valid_cnt", 32'(valid_cnt - v0), 32'd1);
      chk("a5_rx_data",   32'(rx_data),       32'hA5);
      chk("a5_ferr_cnt",  32'(ferr_cnt - f0),  32'd0);
      chk("a5_busy_idle", 32'(rx_busy),       32'h0);

      // Back-to-back 00 then FF with no idle gap
      v0 = valid_cnt;
      send_frame(8'h00, ^8'h00, 1'b1);
      send_frame(8'hFF, ^8'hFF, 1'b1);
      repeat (10) @(negedge clk);
      chk("b2b_valid_cnt", 32'(valid_cnt - v0), 32'd2);
      chk("b2b_first",     32'(log_q[$-1]),     32'h00);
      chk("b2b_second",    32'(log_q[$]),       32'hFF);

      // 100-cycle glitch in IDLE is rejected
      v0 = valid_cnt; f0 = ferr_cnt;
      @(negedge clk) rx = 1'b0;
      repeat (50) @(negedge clk);
      chk("glitch_busy_high", 32'(rx_busy), 32'h1);
      repeat (50) @(negedge clk);
      rx = 1'b1;
      repeat (300) @(negedge clk);
      chk("glitch_busy_low",  32'(rx_busy),        32'h0);
      chk("glitch_valid_cnt", 32'(valid_cnt - v0), 32'd0);
      chk("glitch_ferr_cnt",  32'(ferr_cnt - f0),  32'd0);

      // Byte after glitch
      v0 = valid_cnt;
      send_frame(8'h3C, ^8'h3C, 1'b1);
      repeat (10) @(negedge clk);
      chk("3c_valid_cnt", 32'(valid_cnt - v0), 32'd1);
      chk("3c_rx_data",   32'(rx_data),       32'h3C);

      // Stop bit low on 55: framing error, data held
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(8'h55, ^8'h55, 1'b0);
      chk("ferr_cnt",       32'(ferr_cnt - f0),  32'd1);
      chk("ferr_valid_cnt", 32'(valid_cnt - v0), 32'd0);
      chk("ferr_rx_data",   32'(rx_data),       32'h3C);
      @(negedge clk) rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      chk("ferr_busy_low",  32'(rx_busy),       32'h0);

      // Reset in the middle of the data bits
      v0 = valid_cnt; f0 = ferr_cnt;
      bit_time(1'b0);
      bit_time(1'b1);
      bit_time(1'b1);
      repeat (100) @(negedge clk);
      chk("mid_busy_high", 32'(rx_busy), 32'h1);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_reset_rx_data", 32'(rx_data),  32'h00);
      chk("mid_reset_busy",    32'(rx_busy),  32'h0);
      chk("mid_reset_valid",   32'(rx_valid), 32'h0);
      reset_n = 1'b1;
      repeat (12 * CPB) @(negedge clk);
      chk("mid_no_strobe", 32'((valid_cnt - v0) + (ferr_cnt - f0)), 32'd0);
      send_frame(8'hC3, ^8'hC3, 1'b1);
      repeat (10) @(negedge clk);
      chk("c3_valid_cnt", 32'(valid_cnt - v0), 32'd1);
      chk("c3_rx_data",   32'(rx_data),       32'hC3);

`ifdef UART_RX_PARITY_EN
      // A5 with wrong parity bit
      v0 = valid_cnt; p0 = perr_cnt; f0 = ferr_cnt;
      send_frame(8'hA5, 1'b1, 1'b1);
      repeat (10) @(negedge clk);
      chk("par_perr_cnt",  32'(perr_cnt - p0),  32'd1);
      chk("par_valid_cnt", 32'(valid_cnt - v0), 32'd0);
      chk("par_ferr_cnt",  32'(ferr_cnt - f0),  32'd0);
      chk("par_rx_data",   32'(rx_data),       32'hC3);
`else
      p0 = 0;
      chk("no_parity_err", 32'(perr_cnt - p0), 32'd0);
`endif

      chk("strobe_adjacency", 32'(adj_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
